// File: rtl/mrp_write_issuer.sv
// Write-side feeder for the must-read-protected cache: FIFO-buffers producer writes
// and issues them one at a time, retrying nacked writes. Optional MRP_WRITE_ROTATE_ON_NACK_EN.
//   state   | meaning
//   IDLE    | nothing in flight, wait for an entry
//   ISSUE   | ce/we high with the head entry
//   WAIT    | sample the registered write ack
//   BACKOFF | idle cycles before re-issuing a nacked write
module mrp_write_issuer #(
  parameter int DEPTH_BITS     = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int BACKOFF_CYCLES = 2,
  parameter int MAX_RETRIES    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  cache_ce_o,
  output logic                  cache_we_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  input  logic                  cache_wack_i,
  output logic [DEPTH_BITS:0]   fifo_count_o,
  output logic                  stuck_o,
  output logic                  idle_o
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;
  localparam int PW    = DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam int RW    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int BW    = (BACKOFF_CYCLES > 0) ? $clog2(BACKOFF_CYCLES + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [RW-1:0] MAX_RET  = RW'(MAX_RETRIES);
  localparam logic [BW-1:0] BO_LOAD  = BW'(BACKOFF_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d, cnt_rem;
  logic [RW-1:0]   retry_q, retry_d;
  logic [BW-1:0]   bo_q, bo_d;
  logic            stuck_q, stuck_d;
  logic            ce_q, ce_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic            push, pop, rot;
  logic [EW-1:0]   head, head_next;

  assign in_ready_o    = (count_q < FULL_CNT);
  assign cache_ce_o    = ce_q;
  assign cache_we_o    = ce_q;
  assign cache_addr_o  = addr_q;
  assign cache_wdata_o = wdata_q;
  assign fifo_count_o  = count_q;
  assign stuck_o       = stuck_q;
  assign idle_o        = (state_q == S_IDLE) && (count_q == '0);

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    stuck_d   = stuck_q;
    bo_d      = bo_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_d     = mem_q;
    pop       = 1'b0;
    rot       = 1'b0;
    push      = in_valid_i && in_ready_o;
    head      = mem_q[rd_ptr_q];

    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cache_wack_i) begin
          pop     = 1'b1;
          retry_d = '0;
          stuck_d = 1'b0;
          state_d = (count_q > CW'(1) || push) ? S_ISSUE : S_IDLE;
        end else begin
          if (retry_q != MAX_RET) retry_d = retry_q + RW'(1);
          stuck_d = (retry_d == MAX_RET);
`ifdef MRP_WRITE_ROTATE_ON_NACK_EN
          // Recycle the blocked head to the tail so other slots can drain.
          rot = (count_q > CW'(1));
          pop = rot;
`endif
          if (BACKOFF_CYCLES > 0) begin
            state_d = S_BACKOFF;
            bo_d    = BO_LOAD;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_BACKOFF: begin
        if (bo_q <= BW'(1)) state_d = S_ISSUE;
        else                bo_d    = bo_q - BW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push) + PW'(rot);
    count_d  = count_q + CW'(push) + CW'(rot) - CW'(pop);
    if (rot)  mem_d[wr_ptr_q] = head;
    if (push) mem_d[wr_ptr_q + PW'(rot)] = {in_addr_i, in_data_i};

    // An entry pushed this very cycle into a drained FIFO is not in mem_q yet.
    cnt_rem   = count_q - CW'(pop);
    head_next = (cnt_rem == '0) ? {in_addr_i, in_data_i} : mem_q[rd_ptr_d];
    ce_d      = (state_d == S_ISSUE);
    if (ce_d) begin
      addr_d  = head_next[EW-1:DATA_WIDTH];
      wdata_d = head_next[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      retry_q  <= '0;
      stuck_q  <= 1'b0;
      bo_q     <= '0;
      ce_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      retry_q  <= retry_d;
      stuck_q  <= stuck_d;
      bo_q     <= bo_d;
      ce_q     <= ce_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: tb/tb_mrp_write_issuer.sv
// Directed bench for mrp_write_issuer: vector table for issue/order/full/rotate flows,
// hand sequences for retry spacing, stuck_o and async reset mid-write.
module tb_mrp_write_issuer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  in_addr_i = '0;
  logic [15:0] in_data_i = '0;
  logic        cache_ce_o, cache_we_o;
  logic [7:0]  cache_addr_o;
  logic [15:0] cache_wdata_o;
  logic        cache_wack_i = 1'b0;
  logic [2:0]  fifo_count_o;
  logic        stuck_o, idle_o;

  int checks = 0;
  int failures = 0;

  mrp_write_issuer dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_addr_i(in_addr_i), .in_data_i(in_data_i),
    .cache_ce_o(cache_ce_o), .cache_we_o(cache_we_o),
    .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o),
    .cache_wack_i(cache_wack_i), .fifo_count_o(fifo_count_o),
    .stuck_o(stuck_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  a;
    logic [15:0] d;
    logic        w;
    logic        ce;
    logic [7:0]  ea;
    logic [15:0] ed;
    logic [2:0]  cnt;
    logic        rdy;
    logic        idle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] a, logic [15:0] d, logic w,
                              logic ce, logic [7:0] ea, logic [15:0] ed,
                              logic [2:0] cnt, logic rdy, logic idle);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.w = w; r.ce = ce; r.ea = ea; r.ed = ed;
    r.cnt = cnt; r.rdy = rdy; r.idle = idle;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic [15:0] d, input logic w);
    @(negedge clk);
    in_valid_i = v; in_addr_i = a; in_data_i = d; cache_wack_i = w;
    @(posedge clk);
    #1;
  endtask

  task automatic run_retry(input int nacks, input logic [7:0] a, input logic [15:0] d);
    int n, since, last;
    logic w, in_wait, done;
    n = 0; since = 99; last = 0; done = 1'b0;
    step(1'b1, a, d, 1'b0);
    for (int c = 0; c < 120 && !done; c++) begin
      in_wait = (since == 1);
      w = in_wait && (n == nacks + 1);
      step(1'b0, 8'h00, 16'h0000, w);
      if (in_wait)
        chk($sformatf("retry%0d_stuck_after_issue%0d", nacks, n), 32'(stuck_o),
            32'((!w && n >= 15) ? 1 : 0));
      if (w) begin
        chk($sformatf("retry%0d_pop_count", nacks), 32'(fifo_count_o), 32'd0);
        done = 1'b1;
      end
      if (cache_ce_o) begin
        n++;
        chk($sformatf("retry%0d_addr%0d", nacks, n), 32'(cache_addr_o), 32'(a));
        chk($sformatf("retry%0d_data%0d", nacks, n), 32'(cache_wdata_o), 32'(d));
        if (n > 1) chk($sformatf("retry%0d_spacing%0d", nacks, n), 32'(c - last), 32'd4);
        last = c;
        since = 0;
      end else begin
        since++;
      end
    end
    chk($sformatf("retry%0d_completed", nacks), 32'(done), 32'd1);
    chk($sformatf("retry%0d_issue_count", nacks), 32'(n), 32'(nacks + 1));
  endtask

  initial begin
    // single write, ack arriving in ISSUE is ignored, ack in WAIT pops
    vecs.push_back(mk(1, 8'h05, 16'hABCD, 0,  0, 8'h00, 16'h0000, 3'd1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  1, 8'h05, 16'hABCD, 3'd1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  0, 8'h00, 16'h0000, 3'd1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  0, 8'h00, 16'h0000, 3'd0, 1, 1));
    // fill to full, 5th push dropped, in-order drain
    vecs.push_back(mk(1, 8'h01, 16'h1001, 0,  0, 8'h00, 16'h0000, 3'd1, 1, 0));
    vecs.push_back(mk(1, 8'h02, 16'h1002, 0,  1, 8'h01, 16'h1001, 3'd2, 1, 0));
    vecs.push_back(mk(1, 8'h03, 16'h1003, 0,  0, 8'h00, 16'h0000, 3'd3, 1, 0));
    vecs.push_back(mk(1, 8'h04, 16'h1004, 0,  0, 8'h00, 16'h0000, 3'd4, 0, 0));
    vecs.push_back(mk(1, 8'h05, 16'h1005, 0,  0, 8'h00, 16'h0000, 3'd4, 0, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  1, 8'h01, 16'h1001, 3'd4, 0, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd4, 0, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  1, 8'h02, 16'h1002, 3'd3, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd3, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  1, 8'h03, 16'h1003, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  1, 8'h04, 16'h1004, 3'd1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  0, 8'h00, 16'h0000, 3'd0, 1, 1));
    // A nacked once, then two acks: rotate build issues A,B,A; in-order build A,A,B
    vecs.push_back(mk(1, 8'h10, 16'hAAAA, 0,  0, 8'h00, 16'h0000, 3'd1, 1, 0));
    vecs.push_back(mk(1, 8'h21, 16'hBBBB, 0,  1, 8'h10, 16'hAAAA, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd2, 1, 0));
`ifdef MRP_WRITE_ROTATE_ON_NACK_EN
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  1, 8'h21, 16'hBBBB, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  1, 8'h10, 16'hAAAA, 3'd1, 1, 0));
`else
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  1, 8'h10, 16'hAAAA, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  1, 8'h21, 16'hBBBB, 3'd1, 1, 0));
`endif
    vecs.push_back(mk(0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 16'h0000, 1,  0, 8'h00, 16'h0000, 3'd0, 1, 1));

    #12;
    chk("rst_ce", 32'(cache_ce_o), 32'd0);
    chk("rst_we", 32'(cache_we_o), 32'd0);
    chk("rst_addr", 32'(cache_addr_o), 32'd0);
    chk("rst_wdata", 32'(cache_wdata_o), 32'd0);
    chk("rst_stuck", 32'(stuck_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].w);
      chk($sformatf("vec%0d_ce", i), 32'(cache_ce_o), 32'(vecs[i].ce));
      chk($sformatf("vec%0d_we", i), 32'(cache_we_o), 32'(vecs[i].ce));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count_o), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready_o), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_idle", i), 32'(idle_o), 32'(vecs[i].idle));
      chk($sformatf("vec%0d_stuck", i), 32'(stuck_o), 32'd0);
      if (vecs[i].ce) begin
        chk($sformatf("vec%0d_addr", i), 32'(cache_addr_o), 32'(vecs[i].ea));
        chk($sformatf("vec%0d_data", i), 32'(cache_wdata_o), 32'(vecs[i].ed));
      end
    end

    run_retry(3, 8'h33, 16'h3333);
    run_retry(15, 8'h5A, 16'hC3C3);

    // async reset while WAIT holds three entries
    step(1'b1, 8'h41, 16'h4141, 1'b0);
    step(1'b1, 8'h42, 16'h4242, 1'b0);
    step(1'b1, 8'h43, 16'h4343, 1'b0);
    chk("midrst_pre_count", 32'(fifo_count_o), 32'd3);
    @(negedge clk);
    in_valid_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_ce", 32'(cache_ce_o), 32'd0);
    chk("midrst_we", 32'(cache_we_o), 32'd0);
    chk("midrst_count", 32'(fifo_count_o), 32'd0);
    chk("midrst_idle", 32'(idle_o), 32'd1);
    chk("midrst_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 8'h00, 16'h0000, 1'b1);
    chk("postrst_ack_count", 32'(fifo_count_o), 32'd0);
    chk("postrst_ack_ce", 32'(cache_ce_o), 32'd0);
    chk("postrst_ack_idle", 32'(idle_o), 32'd1);
    step(1'b0, 8'h00, 16'h0000, 1'b0);
    chk("postrst_settle_count", 32'(fifo_count_o), 32'd0);
    chk("postrst_settle_ce", 32'(cache_ce_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
